// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe: two-stage valid/ready pipeline for Gray encode, decode and Gray increment.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready            input handshake, in_data operand, in_mode operation
//                                (00 bin->gray, 01 gray->bin, 10 gray increment, 11 illegal)
//   out_valid/out_ready          output handshake, out_data result, out_mode echoed mode,
//                                out_err set for illegal mode
module gray_codec_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_mode,
    output logic             out_err
);
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic [1:0]       s1_mode_q, s1_mode_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_data_q, s2_data_d;
    logic [1:0]       s2_mode_q, s2_mode_d;
    logic             s2_err_q, s2_err_d;
    logic             accept, advance;
    logic [WIDTH-1:0] result;

    function automatic logic [WIDTH-1:0] b2g(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down: bit i is the XOR of all Gray bits at or above i.
    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = g;
        for (int i = 1; i < WIDTH; i++) b = b ^ (g >> i);
        return b;
    endfunction

    assign in_ready  = !s1_valid_q || !s2_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    // S1 may move forward only into an empty S2 or one being drained this cycle.
    assign advance   = s1_valid_q && (!s2_valid_q || out_ready);
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_mode  = s2_mode_q;
    assign out_err   = s2_err_q;

    always_comb begin
        result     = s1_mode_q == 2'b00 ? b2g(s1_data_q) :
                     s1_mode_q == 2'b01 ? g2b(s1_data_q) :
                     s1_mode_q == 2'b10 ? b2g(g2b(s1_data_q) + WIDTH'(1)) : '0;
        s1_valid_d = accept || (s1_valid_q && !advance);
        s1_data_d  = accept ? in_data : s1_data_q;
        s1_mode_d  = accept ? in_mode : s1_mode_q;
        s2_valid_d = advance || (s2_valid_q && !out_ready);
        s2_data_d  = advance ? result : s2_data_q;
        s2_mode_d  = advance ? s1_mode_q : s2_mode_q;
        s2_err_d   = advance ? (s1_mode_q == 2'b11) : s2_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= 2'b00;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_mode_q  <= 2'b00;
            s2_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_mode_q  <= s2_mode_d;
            s2_err_q   <= s2_err_d;
        end
    end
endmodule

// File: tb/tb_gray_codec_pipe.sv
// tb_gray_codec_pipe: directed vector bench for gray_codec_pipe (WIDTH=8 and WIDTH=4 instances).
module tb_gray_codec_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid, in_ready, out_valid, out_ready, out_err;
    logic [7:0] in_data, out_data;
    logic [1:0] in_mode, out_mode;
    logic       v4, r4, ov4, or4, oe4;
    logic [3:0] d4, od4;
    logic [1:0] m4, om4;
    int         total = 0;
    int         bad = 0;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] din;
        logic [7:0] dout;
        logic       err;
    } vec_t;
    vec_t vecs[13];

    always #5 clk = ~clk;

    gray_codec_pipe #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mode(out_mode), .out_err(out_err)
    );

    gray_codec_pipe #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v4), .in_ready(r4), .in_data(d4), .in_mode(m4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4),
        .out_mode(om4), .out_err(oe4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_s[4];
        logic [7:0] held;
        logic       held_v;
        int         sent, got, stale;
        exp_s = '{8'h01, 8'h03, 8'h02, 8'h06};
        vecs[0]  = '{2'b00, 8'h2D, 8'h3B, 1'b0};
        vecs[1]  = '{2'b01, 8'h3B, 8'h2D, 1'b0};
        vecs[2]  = '{2'b10, 8'h80, 8'h00, 1'b0};
        vecs[3]  = '{2'b10, 8'h00, 8'h01, 1'b0};
        vecs[4]  = '{2'b11, 8'hA5, 8'h00, 1'b1};
        vecs[5]  = '{2'b00, 8'hFF, 8'h80, 1'b0};
        vecs[6]  = '{2'b01, 8'h80, 8'hFF, 1'b0};
        vecs[7]  = '{2'b00, 8'h0B, 8'h0E, 1'b0};
        vecs[8]  = '{2'b10, 8'h01, 8'h03, 1'b0};
        vecs[9]  = '{2'b10, 8'h03, 8'h02, 1'b0};
        vecs[10] = '{2'b01, 8'h00, 8'h00, 1'b0};
        vecs[11] = '{2'b00, 8'h80, 8'hC0, 1'b0};
        vecs[12] = '{2'b10, 8'hC0, 8'hC1, 1'b0};
        in_valid = 1'b1; in_data = 8'h55; in_mode = 2'b11; out_ready = 1'b1;
        v4 = 1'b0; d4 = 4'h0; m4 = 2'b00; or4 = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_mode", out_mode, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_in_ready", in_ready, 1);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b1; in_data = 8'h2D; in_mode = 2'b00;
        #1 chk("rel_in_ready", in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        chk("rel_lat1_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("rel_lat2_valid", out_valid, 1);
        chk("rel_lat2_data", out_data, 8'h3B);
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1; in_mode = vecs[i].mode; in_data = vecs[i].din;
            @(posedge clk); #1 in_valid = 1'b0;
            chk($sformatf("vec%0d_early", i), out_valid, 0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_data", i), out_data, vecs[i].dout);
            chk($sformatf("vec%0d_mode", i), out_mode, vecs[i].mode);
            chk($sformatf("vec%0d_err", i), out_err, vecs[i].err);
        end
        @(posedge clk); #1;

        in_valid = 1'b1; in_data = 8'h2D; in_mode = 2'b00;
        @(posedge clk); #1 in_data = 8'h3B; in_mode = 2'b01;
        @(posedge clk); #1 in_valid = 1'b0;
        chk("b2b_a", {out_valid, out_mode, out_data}, {1'b1, 2'b00, 8'h3B});
        @(posedge clk); #1;
        chk("b2b_b", {out_valid, out_mode, out_data}, {1'b1, 2'b01, 8'h2D});
        @(posedge clk); #1;
        chk("b2b_empty", out_valid, 0);

        v4 = 1'b1; d4 = 4'b1011; m4 = 2'b00;
        @(posedge clk); #1 v4 = 1'b0;
        chk("w4_early", ov4, 0);
        @(posedge clk); #1;
        chk("w4_result", {ov4, oe4, od4}, {1'b1, 1'b0, 4'b1110});
        @(posedge clk); #1;

        sent = 0; got = 0; held_v = 1'b0; held = 8'h00;
        for (int c = 0; c < 30 && got < 4; c++) begin
            in_valid = sent < 4; in_data = 8'(sent + 1); in_mode = 2'b00; out_ready = c >= 5;
            #1;
            if (c == 2) chk("stall_in_ready", {in_ready, 8'(sent)}, {1'b0, 8'd2});
            if (held_v) chk($sformatf("stall_hold%0d", c), {out_valid, out_data}, {1'b1, held});
            held_v = out_valid && !out_ready;
            held = out_data;
            if (out_valid && out_ready) begin
                chk($sformatf("stall_out%0d", got), out_data, exp_s[got]);
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("stall_count", got, 4);
        @(posedge clk); #1;

        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h10; in_mode = 2'b00;
        @(posedge clk); #1 in_data = 8'h20;
        @(posedge clk); #1 in_valid = 1'b0;
        chk("flight_valid", {out_valid, out_data}, {1'b1, 8'h18});
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1; out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        chk("no_stale", stale, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
